// File: rtl/control_sequencer_pkg.sv
// Shared opcode constants, FSM state encoding and the datapath flag bundle.
package control_sequencer_pkg;

  localparam int unsigned OPC_W   = 7;
  localparam int unsigned STATE_W = 4;

  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_FENCE  = 7'b0001111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE,
    ST_F_SETUP,
    ST_F_ACCESS,
    ST_EXECUTE,
    ST_M_SETUP,
    ST_M_ACCESS,
    ST_T_SAVE_SETUP,
    ST_T_SAVE_ACCESS,
    ST_T_VEC_SETUP,
    ST_T_VEC_ACCESS,
    ST_T_JUMP,
    ST_HALT
  } state_e;

  // Datapath mux selects and write enables driven by the sequencer
  typedef struct packed {
    logic microop_pc_zero;
    logic mem_access;
    logic sys_load;
    logic sys_load_pc;
    logic lui_flag;
    logic jal_flag;
    logic store_alu;
    logic load_branch;
    logic load_jalr;
    logic load_pc;
    logic alu_rs1;
    logic alu_imm_i;
    logic immediate;
    logic ir_we;
    logic pc_we;
    logic rd_we;
    logic halted;
  } ctrl_flags_t;

endpackage

// File: rtl/control_sequencer_if.sv
// APB master/completer handshake between the sequencer and the bus.
interface control_sequencer_if;
  logic psel;
  logic penable;
  logic pwrite;
  logic pready;
  logic pslverr;

  modport master (output psel, penable, pwrite, input pready, pslverr);
  modport slave  (input psel, penable, pwrite, output pready, pslverr);
endinterface

// File: rtl/control_sequencer_apb_timeout_counter.sv
// Counts stalled APB access cycles and flags when the limit is reached.
module control_sequencer_apb_timeout_counter #(
  parameter int unsigned APB_TIMEOUT = 255,
  parameter int unsigned TW          = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_expired
);

  logic [TW-1:0] r_count;

  // Stall counter: cleared in SETUP, advances while the completer holds off
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_count_en) begin
      r_count <= r_count + TW'(1);
    end
  end

  // A limit of zero disables the timeout entirely
  assign o_expired = (APB_TIMEOUT != 0) && (r_count == TW'(APB_TIMEOUT));

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle RV32I control FSM: fetch, execute, memory and trap microops over APB.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int unsigned APB_TIMEOUT = 255,
  parameter int unsigned TW          = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          instruction,
  input  logic                 branch_taken,
  control_sequencer_if.master  apb,
  output logic                 microop_pc_zero,
  output logic                 mem_access,
  output logic                 sys_load,
  output logic                 sys_load_pc,
  output logic                 lui_flag,
  output logic                 jal_flag,
  output logic                 store_alu,
  output logic                 load_branch,
  output logic                 load_jalr,
  output logic                 load_pc,
  output logic                 alu_rs1,
  output logic                 alu_imm_i,
  output logic                 immediate,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 rd_we,
  output logic                 halted
);

  state_e           r_state;
  state_e           w_next;
  ctrl_flags_t      w_flags;
  logic             w_psel;
  logic             w_penable;
  logic             w_pwrite;
  logic [OPC_W-1:0] w_opc;
  logic             w_rd_zero;
  logic             w_is_load;
  logic             w_setup;
  logic             w_access;
  logic             w_expired;
  logic             w_ok;
  logic             w_err;
  logic             w_unused_instr;

  assign w_opc          = instruction[6:0];
  assign w_rd_zero      = (instruction[11:7] == 5'd0);
  assign w_is_load      = (w_opc == OPC_LOAD);
  assign w_unused_instr = ^instruction[31:12];

  assign w_setup  = (r_state == ST_F_SETUP) || (r_state == ST_M_SETUP) ||
                    (r_state == ST_T_SAVE_SETUP) || (r_state == ST_T_VEC_SETUP);
  assign w_access = (r_state == ST_F_ACCESS) || (r_state == ST_M_ACCESS) ||
                    (r_state == ST_T_SAVE_ACCESS) || (r_state == ST_T_VEC_ACCESS);

  // Timeout counts as a completer error, even if pready arrives on that cycle
  assign w_err = w_access & ((apb.pready & apb.pslverr) | w_expired);
  assign w_ok  = w_access & apb.pready & ~apb.pslverr & ~w_expired;

  control_sequencer_apb_timeout_counter #(
    .APB_TIMEOUT (APB_TIMEOUT),
    .TW          (TW)
  ) u_timeout (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_setup),
    .i_count_en (w_access & ~apb.pready),
    .o_expired  (w_expired)
  );

  // State register; reset lands in IDLE so all strobes drop immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and output decode from state, opcode and bus response
  always_comb begin
    w_next    = r_state;
    w_flags   = '0;
    w_psel    = 1'b0;
    w_penable = 1'b0;
    w_pwrite  = 1'b0;
    case (r_state)
      ST_IDLE: w_next = ST_F_SETUP;
      ST_F_SETUP: begin
        w_flags.microop_pc_zero = 1'b1;
        w_psel                  = 1'b1;
        w_next                  = ST_F_ACCESS;
      end
      ST_F_ACCESS: begin
        w_flags.microop_pc_zero = 1'b1;
        w_psel                  = 1'b1;
        w_penable               = 1'b1;
        if (w_ok) begin
          w_flags.ir_we = 1'b1;
          w_flags.pc_we = 1'b1;
          w_next        = ST_EXECUTE;
        end else if (w_err) begin
          w_next = ST_T_SAVE_SETUP;
        end
      end
      ST_EXECUTE: begin
        w_next = ST_F_SETUP;
        case (w_opc)
          OPC_OP: begin
            w_flags.alu_rs1   = 1'b1;
            w_flags.store_alu = 1'b1;
            w_flags.rd_we     = 1'b1;
          end
          OPC_OP_IMM: begin
            w_flags.alu_imm_i = 1'b1;
            w_flags.immediate = 1'b1;
            w_flags.store_alu = 1'b1;
            w_flags.rd_we     = 1'b1;
          end
          OPC_LUI, OPC_AUIPC: begin
            w_flags.lui_flag = 1'b1;
            w_flags.rd_we    = 1'b1;
          end
          OPC_JAL: begin
            w_flags.jal_flag = 1'b1;
            w_flags.pc_we    = 1'b1;
            w_flags.rd_we    = 1'b1;
          end
          OPC_JALR: begin
            w_flags.alu_imm_i = 1'b1;
            w_flags.load_jalr = 1'b1;
            w_flags.load_pc   = 1'b1;
            w_flags.pc_we     = 1'b1;
            w_flags.rd_we     = 1'b1;
          end
          OPC_BRANCH: begin
            w_flags.alu_rs1     = 1'b1;
            w_flags.load_branch = 1'b1;
            w_flags.pc_we       = branch_taken;
          end
          OPC_LOAD: begin
            w_flags.alu_imm_i = 1'b1;
            w_next            = ST_M_SETUP;
          end
          OPC_STORE: begin
            w_pwrite = 1'b1;
            w_next   = ST_M_SETUP;
          end
          OPC_FENCE: w_next = ST_F_SETUP;
          OPC_SYSTEM: w_next = ST_T_SAVE_SETUP;
          default: w_next = ST_T_SAVE_SETUP;
        endcase
      end
      ST_M_SETUP: begin
        w_flags.mem_access = 1'b1;
        w_flags.alu_imm_i  = w_is_load;
        w_pwrite           = ~w_is_load;
        w_psel             = 1'b1;
        w_next             = ST_M_ACCESS;
      end
      ST_M_ACCESS: begin
        w_flags.mem_access = 1'b1;
        w_flags.alu_imm_i  = w_is_load;
        w_pwrite           = ~w_is_load;
        w_psel             = 1'b1;
        w_penable          = 1'b1;
        if (w_ok) begin
          w_flags.rd_we = w_is_load;
          w_next        = ST_F_SETUP;
        end else if (w_err) begin
          w_next = ST_T_SAVE_SETUP;
        end
      end
      ST_T_SAVE_SETUP: begin
        w_flags.sys_load = 1'b1;
        w_pwrite         = 1'b1;
        w_psel           = 1'b1;
        w_next           = ST_T_SAVE_ACCESS;
      end
      ST_T_SAVE_ACCESS: begin
        w_flags.sys_load = 1'b1;
        w_pwrite         = 1'b1;
        w_psel           = 1'b1;
        w_penable        = 1'b1;
        if (w_ok) begin
          w_next = ST_T_VEC_SETUP;
        end else if (w_err) begin
          w_next = ST_HALT;
        end
      end
      ST_T_VEC_SETUP: begin
        w_flags.sys_load = 1'b1;
        w_psel           = 1'b1;
        w_next           = ST_T_VEC_ACCESS;
      end
      ST_T_VEC_ACCESS: begin
        w_flags.sys_load = 1'b1;
        w_psel           = 1'b1;
        w_penable        = 1'b1;
        if (w_ok) begin
          w_flags.ir_we = 1'b1;
          w_next        = ST_T_JUMP;
        end else if (w_err) begin
          w_next = ST_HALT;
        end
      end
      ST_T_JUMP: begin
        w_flags.sys_load_pc = 1'b1;
        w_flags.pc_we       = 1'b1;
        w_next              = ST_F_SETUP;
      end
      ST_HALT: w_flags.halted = 1'b1;
      default: w_next = ST_IDLE;
    endcase
    // x0 is hardwired; never write it
    if (w_rd_zero) begin
      w_flags.rd_we = 1'b0;
    end
  end

  assign apb.psel        = w_psel;
  assign apb.penable     = w_penable;
  assign apb.pwrite      = w_pwrite;
  assign microop_pc_zero = w_flags.microop_pc_zero;
  assign mem_access      = w_flags.mem_access;
  assign sys_load        = w_flags.sys_load;
  assign sys_load_pc     = w_flags.sys_load_pc;
  assign lui_flag        = w_flags.lui_flag;
  assign jal_flag        = w_flags.jal_flag;
  assign store_alu       = w_flags.store_alu;
  assign load_branch     = w_flags.load_branch;
  assign load_jalr       = w_flags.load_jalr;
  assign load_pc         = w_flags.load_pc;
  assign alu_rs1         = w_flags.alu_rs1;
  assign alu_imm_i       = w_flags.alu_imm_i;
  assign immediate       = w_flags.immediate;
  assign ir_we           = w_flags.ir_we;
  assign pc_we           = w_flags.pc_we;
  assign rd_we           = w_flags.rd_we;
  assign halted          = w_flags.halted;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: table vectors, corner sequences, random instruction stream.
module tb_control_sequencer;

  localparam int unsigned TMO = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        branch_taken;
  logic microop_pc_zero, mem_access, sys_load, sys_load_pc, lui_flag, jal_flag;
  logic store_alu, load_branch, load_jalr, load_pc, alu_rs1, alu_imm_i, immediate;
  logic ir_we, pc_we, rd_we, halted;

  control_sequencer_if apb();

  control_sequencer #(.APB_TIMEOUT(TMO), .TW(8)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .branch_taken(branch_taken),
    .apb(apb),
    .microop_pc_zero(microop_pc_zero), .mem_access(mem_access), .sys_load(sys_load),
    .sys_load_pc(sys_load_pc), .lui_flag(lui_flag), .jal_flag(jal_flag),
    .store_alu(store_alu), .load_branch(load_branch), .load_jalr(load_jalr),
    .load_pc(load_pc), .alu_rs1(alu_rs1), .alu_imm_i(alu_imm_i), .immediate(immediate),
    .ir_we(ir_we), .pc_we(pc_we), .rd_we(rd_we), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic psel, penable, pwrite;
    logic microop_pc_zero, mem_access, sys_load, sys_load_pc, lui_flag, jal_flag;
    logic store_alu, load_branch, load_jalr, load_pc, alu_rs1, alu_imm_i, immediate;
    logic ir_we, pc_we, rd_we, halted;
  } outs_t;

  typedef struct {
    logic [31:0] ins;
    logic        taken;
    outs_t       exp;
    int          nxt;   // 0: back to fetch, 1: memory access, 2: trap
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] drv_instr = 32'h0;
  logic        drv_taken = 1'b0;
  bit          m_halted = 1'b0;

  function automatic outs_t sample();
    outs_t o;
    o.psel = apb.psel; o.penable = apb.penable; o.pwrite = apb.pwrite;
    o.microop_pc_zero = microop_pc_zero; o.mem_access = mem_access; o.sys_load = sys_load;
    o.sys_load_pc = sys_load_pc; o.lui_flag = lui_flag; o.jal_flag = jal_flag;
    o.store_alu = store_alu; o.load_branch = load_branch; o.load_jalr = load_jalr;
    o.load_pc = load_pc; o.alu_rs1 = alu_rs1; o.alu_imm_i = alu_imm_i; o.immediate = immediate;
    o.ir_we = ir_we; o.pc_we = pc_we; o.rd_we = rd_we; o.halted = halted;
    return o;
  endfunction

  task automatic check(input string name, input outs_t exp);
    outs_t g;
    g = sample();
    checks++;
    if (g !== exp) begin
      failures++;
      $display("FAIL %s: outputs got %05h expected %05h (instr %08h)", name, g, exp, instruction);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock cycle: drive on the falling edge, compare shortly after
  task automatic step(input logic rdy, input logic err, input outs_t exp, input string name);
    @(negedge clk);
    instruction  = drv_instr;
    branch_taken = drv_taken;
    apb.pready   = rdy;
    apb.pslverr  = err;
    #1;
    check(name, exp);
  endtask

  // Expected execute-cycle flags straight from the opcode table
  function automatic outs_t exp_exec(input logic [31:0] ins, input logic taken, output int nxt);
    outs_t e;
    e = '0;
    nxt = 0;
    case (ins[6:0])
      7'b0110011: begin e.alu_rs1 = 1; e.store_alu = 1; e.rd_we = 1; end
      7'b0010011: begin e.alu_imm_i = 1; e.immediate = 1; e.store_alu = 1; e.rd_we = 1; end
      7'b0110111, 7'b0010111: begin e.lui_flag = 1; e.rd_we = 1; end
      7'b1101111: begin e.jal_flag = 1; e.pc_we = 1; e.rd_we = 1; end
      7'b1100111: begin e.alu_imm_i = 1; e.load_jalr = 1; e.load_pc = 1; e.pc_we = 1; e.rd_we = 1; end
      7'b1100011: begin e.alu_rs1 = 1; e.load_branch = 1; e.pc_we = taken; end
      7'b0000011: begin e.alu_imm_i = 1; nxt = 1; end
      7'b0100011: begin e.pwrite = 1; nxt = 1; end
      7'b0001111: nxt = 0;
      default: nxt = 2;
    endcase
    if (ins[11:7] == 5'd0) e.rd_we = 0;
    return e;
  endfunction

  // One APB transfer: SETUP, `stall` waits, then completion, error or timeout
  task automatic xfer(input outs_t base, input outs_t we, input int stall, input logic err,
                      input string name, output logic ok);
    outs_t e;
    e = base;
    e.psel = 1;
    step(rbit(), rbit(), e, {name, "_setup"});
    e.penable = 1;
    if (stall >= int'(TMO)) begin
      for (int i = 0; i < int'(TMO); i++) step(1'b0, rbit(), e, {name, "_wait"});
      step(1'b0, rbit(), e, {name, "_timeout"});
      ok = 1'b0;
    end else begin
      for (int i = 0; i < stall; i++) step(1'b0, rbit(), e, {name, "_wait"});
      step(1'b1, err, err ? e : outs_t'(e | we), {name, "_done"});
      ok = !err;
    end
  endtask

  task automatic halt_check();
    outs_t e;
    e = '0;
    e.halted = 1;
    m_halted = 1'b1;
    for (int i = 0; i < 3; i++) step(rbit(), rbit(), e, "halt");
  endtask

  task automatic trap(input int sst, input logic serr, input int vst, input logic verr);
    outs_t e, we;
    logic ok;
    e = '0; e.sys_load = 1; e.pwrite = 1;
    xfer(e, '0, sst, serr, "tsave", ok);
    if (!ok) begin halt_check(); return; end
    e.pwrite = 0;
    we = '0; we.ir_we = 1;
    xfer(e, we, vst, verr, "tvec", ok);
    if (!ok) begin halt_check(); return; end
    e = '0; e.sys_load_pc = 1; e.pc_we = 1;
    step(rbit(), rbit(), e, "tjump");
  endtask

  task automatic run_instr(input logic [31:0] ins, input logic taken, input outs_t ex, input int nxt,
                           input int fst, input logic ferr, input int mst, input logic merr,
                           input int sst, input logic serr, input int vst, input logic verr);
    outs_t e, we;
    logic ok;
    drv_instr = ins;
    drv_taken = taken;
    e = '0; e.microop_pc_zero = 1;
    we = '0; we.ir_we = 1; we.pc_we = 1;
    xfer(e, we, fst, ferr, "fetch", ok);
    if (!ok) begin trap(sst, serr, vst, verr); return; end
    step(rbit(), rbit(), ex, "execute");
    if (nxt == 1) begin
      e = '0; e.mem_access = 1;
      if (ins[6:0] == 7'b0000011) e.alu_imm_i = 1; else e.pwrite = 1;
      we = '0;
      we.rd_we = (ins[6:0] == 7'b0000011) && (ins[11:7] != 5'd0);
      xfer(e, we, mst, merr, "mem", ok);
      if (!ok) trap(sst, serr, vst, verr);
    end else if (nxt == 2) begin
      trap(sst, serr, vst, verr);
    end
  endtask

  task automatic run_simple(input logic [31:0] ins, input logic taken, input int fst, input int mst,
                            input logic merr, input int vst);
    outs_t ex;
    int nxt;
    ex = exp_exec(ins, taken, nxt);
    run_instr(ins, taken, ex, nxt, fst, 1'b0, mst, merr, 0, 1'b0, vst, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    apb.pready = 1'b0;
    apb.pslverr = 1'b0;
    #1 check("reset_async", '0);
    @(negedge clk);
    #1 check("reset_hold", '0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("idle", '0);
    m_halted = 1'b0;
  endtask

  function automatic logic [6:0] pick_op(input int k);
    case (k)
      0: return 7'b0110011;  1: return 7'b0010011;  2: return 7'b0110111;
      3: return 7'b0010111;  4: return 7'b1101111;  5: return 7'b1100111;
      6: return 7'b1100011;  7: return 7'b0000011;  8: return 7'b0100011;
      9: return 7'b0001111; 10: return 7'b1110011;
      default: return 7'b1111111;
    endcase
  endfunction

  vec_t vecs [14];

  initial begin
    outs_t e;
    reset = 1'b1;
    instruction = '0;
    branch_taken = 1'b0;
    apb.pready = 1'b0;
    apb.pslverr = 1'b0;

    vecs[0]  = '{32'h00500093, 1'b0, outs_t'{alu_imm_i:1, immediate:1, store_alu:1, rd_we:1, default:0}, 0};
    vecs[1]  = '{32'h002081B3, 1'b0, outs_t'{alu_rs1:1, store_alu:1, rd_we:1, default:0}, 0};
    vecs[2]  = '{32'h00208033, 1'b0, outs_t'{alu_rs1:1, store_alu:1, default:0}, 0};
    vecs[3]  = '{32'h123452B7, 1'b0, outs_t'{lui_flag:1, rd_we:1, default:0}, 0};
    vecs[4]  = '{32'h00001317, 1'b0, outs_t'{lui_flag:1, rd_we:1, default:0}, 0};
    vecs[5]  = '{32'h008000EF, 1'b0, outs_t'{jal_flag:1, pc_we:1, rd_we:1, default:0}, 0};
    vecs[6]  = '{32'h00008067, 1'b0, outs_t'{alu_imm_i:1, load_jalr:1, load_pc:1, pc_we:1, default:0}, 0};
    vecs[7]  = '{32'h00208463, 1'b1, outs_t'{alu_rs1:1, load_branch:1, pc_we:1, default:0}, 0};
    vecs[8]  = '{32'h00208463, 1'b0, outs_t'{alu_rs1:1, load_branch:1, default:0}, 0};
    vecs[9]  = '{32'h0000000F, 1'b0, outs_t'{default:0}, 0};
    vecs[10] = '{32'h0020A023, 1'b0, outs_t'{pwrite:1, default:0}, 1};
    vecs[11] = '{32'h0000A103, 1'b0, outs_t'{alu_imm_i:1, default:0}, 1};
    vecs[12] = '{32'h00000073, 1'b0, outs_t'{default:0}, 2};
    vecs[13] = '{32'h0000007F, 1'b0, outs_t'{default:0}, 2};

    // Reset release, then the opcode table with a zero-wait completer
    do_reset();
    for (int i = 0; i < 14; i++)
      run_instr(vecs[i].ins, vecs[i].taken, vecs[i].exp, vecs[i].nxt,
                0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);

    // LW with three wait states, then the last legal fetch stall
    run_simple(32'h0000A103, 1'b0, 0, 3, 1'b0, 0);
    run_simple(32'h00500093, 1'b0, int'(TMO) - 1, 0, 1'b0, 0);
    // Fetch stalled past the limit enters the trap, next fetch from the vector
    run_simple(32'h00500093, 1'b0, 300, 0, 1'b0, 0);
    run_simple(32'h002081B3, 1'b0, 0, 0, 1'b0, 0);
    // Store error traps; ECALL with a stalled vector read halts
    run_simple(32'h0020A023, 1'b0, 1, 2, 1'b1, 0);
    run_simple(32'h00000073, 1'b0, 0, 0, 1'b0, 300);
    if (!m_halted) begin
      checks++; failures++;
      $display("FAIL halt_model: halted flag got 0 expected 1");
    end

    // Reset during a fetch access drops the strobes without a clock
    do_reset();
    drv_instr = 32'h00500093;
    e = '0; e.microop_pc_zero = 1; e.psel = 1;
    step(1'b0, 1'b0, e, "ma_setup");
    e.penable = 1;
    step(1'b0, 1'b0, e, "ma_access");
    #2 reset = 1'b1;
    apb.pready = 1'b1;
    #1 check("ma_reset_drop", '0);
    @(negedge clk);
    reset = 1'b0;
    apb.pready = 1'b0;
    #1 check("ma_idle", '0);

    // Random instruction stream with random stalls and occasional errors
    for (int n = 0; n < 150; n++) begin
      logic [31:0] ins;
      outs_t ex;
      int nxt;
      if (m_halted) do_reset();
      ins = $urandom;
      ins[6:0] = pick_op(int'($urandom_range(0, 11)));
      if ($urandom_range(0, 7) == 0) ins[11:7] = 5'd0;
      ex = exp_exec(ins, rbit(), nxt);
      run_instr(ins, ex.pc_we, ex, nxt,
                int'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0),
                int'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0),
                int'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0),
                int'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
